arbl2dr_disp_rr: RTL
====================

Name: arbl2dr_disp_rr

Overview:
- Round-robin arbiter and router for the L2-to-directory displacement channel.
- Forward path: merges up to NPORTS L2 slice displacement streams into one registered directory stream, and stamps the source slice index into the node-ID field.
- Return path: steers each directory dack back to the originating slice using that node-ID field, through one registered stage.
- Position: between the per-core L2 slices and the directory aggregator, alongside the request/snack arbiter.

Parameters:
- NPORTS, 2, number of L2 slices; legal values 2 or 4 only.
- DW, 64, displacement payload width in bits.
- AW, 16, dack payload width in bits.
- NID_LSB, 3, bit position of the 2-bit slice field inside both payloads (field is [NID_LSB+1:NID_LSB]).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- l2_disp_valid  in  NPORTS  per-slice displacement valid
- l2_disp_retry  out  NPORTS  per-slice retry (back-pressure)
- l2_disp  in  NPORTS*DW  per-slice payload; slice i occupies [i*DW +: DW]
- dr_disp_valid  out  1  displacement valid to directory
- dr_disp_retry  in  1  directory retry
- dr_disp  out  DW  displacement payload to directory, with slice field stamped
- dr_dack_valid  in  1  dack valid from directory
- dr_dack_retry  out  1  retry to directory
- dr_dack  in  AW  dack payload
- l2_dack_valid  out  NPORTS  one-hot dack valid to slices
- l2_dack_retry  in  NPORTS  per-slice dack retry
- l2_dack  out  AW  dack payload, broadcast to all slices

Behaviour:
- Handshake rule: a transfer occurs on a channel in a cycle where valid=1 and retry=0. The sender holds valid and payload stable while retry=1.
- Reset (asynchronous, active-high):
  - dr_disp_valid=0, l2_dack_valid=0.
  - Round-robin pointer ptr=0.
  - Both output registers empty; their payload is don't-care.
  - A reset mid-transfer discards any held entry; no replay.
- Disp arbitration:
  - free = ~full | ~dr_disp_retry.
  - Grant goes to the first valid slice searching ptr, ptr+1, … modulo NPORTS.
  - If free and a grant exists:
    - the register loads the granted payload, with [NID_LSB+1:NID_LSB] replaced by the grant index (2'b00..2'b11); all other bits pass unchanged;
    - full <= 1;
    - ptr <= (grant+1) mod NPORTS.
  - Else if the held entry is consumed (full & ~dr_disp_retry): full <= 0. Otherwise state holds.
  - ptr changes only on an accepted grant.
  - l2_disp_retry[i] = l2_disp_valid[i] & ~(grant==i & free). Retry is 0 when the slice is not valid.
- Disp timing:
  - Latency: accepted at edge N, visible on dr_disp at N+1.
  - Full throughput: 1 per cycle while dr_disp_retry=0.
  - Simultaneous consume and load in the same cycle is required (no bubble).
- Dack path (same single-register scheme):
  - sel = dr_dack[NID_LSB+1:NID_LSB], truncated to log2(NPORTS) bits; the value is registered as sel_q on load.
  - l2_dack_valid = full_d ? (1<<sel_q) : 0.
  - Entry is consumed when ~l2_dack_retry[sel_q].
  - dr_dack_retry = dr_dack_valid & full_d & l2_dack_retry[sel_q].
  - Retries from non-selected slices are ignored.
- The two paths are fully independent; no ordering is enforced between disp and dack.
- No combinational path from any l2_disp_valid to dr_disp_valid.

Optional Feature:
- Macro: ARBL2DR_PERF_EN.
- When defined, adds output perf_grant_cnt (NPORTS*16 bits): per-slice 16-bit counters of accepted disps. Counters reset to 0 and saturate at 16'hFFFF.
- When undefined, the port and counters are absent.
- Arbitration and timing are identical in both builds.

Test Plan:
- Slices 0 and 1 both valid continuously, dr_disp_retry=0, NPORTS=2 -> grants alternate 0,1,0,1; dr_disp slice field alternates 00,01; l2_disp_retry toggles on the loser each cycle.
- Slice 1 payload 64'h0 held valid, dr_disp_retry=1 for 3 cycles after the first load -> dr_disp stays constant with bits[4:3]=01 and l2_disp_retry[1]=1 for 3 cycles; dr_disp_retry drops -> next entry is loaded with no bubble cycle.
- NPORTS=4, only slice 3 valid, then slices 0 and 3 valid -> slice 3 is granted first, ptr becomes 0, slice 0 is granted next, then slice 3.
- dr_dack with bits[4:3]=10, NPORTS=4, l2_dack_retry=4'b0100 for 2 cycles -> l2_dack_valid=4'b0100 is held; dr_dack_retry=1 for the following dack; delivery completes on the third cycle.
- Assert reset while both registers are full -> valids drop to 0 immediately (asynchronously) and ptr=0; after release, a first request from slice 1 gets granted.
- With ARBL2DR_PERF_EN: send 5 disps from slice 0 -> perf_grant_cnt[15:0]=5; preload a counter to 16'hFFFF -> it saturates and does not wrap.

Source files
------------

// File: rtl/arbl2dr_disp_rr.sv
// Round-robin arbiter merging L2 slice displacement streams onto the directory
// channel, plus the registered dack return path. Optional: ARBL2DR_PERF_EN.
module arbl2dr_disp_rr #(
    parameter int NPORTS  = 2,
    parameter int DW      = 64,
    parameter int AW      = 16,
    parameter int NID_LSB = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    l2_disp_valid,
    output logic [NPORTS-1:0]    l2_disp_retry,
    input  logic [NPORTS*DW-1:0] l2_disp,
    output logic                 dr_disp_valid,
    input  logic                 dr_disp_retry,
    output logic [DW-1:0]        dr_disp,
    input  logic                 dr_dack_valid,
    output logic                 dr_dack_retry,
    input  logic [AW-1:0]        dr_dack,
    output logic [NPORTS-1:0]    l2_dack_valid,
    input  logic [NPORTS-1:0]    l2_dack_retry,
    output logic [AW-1:0]        l2_dack
`ifdef ARBL2DR_PERF_EN
    ,
    output logic [NPORTS*16-1:0] perf_grant_cnt
`endif
);

    localparam int PW = (NPORTS == 4) ? 2 : 1;

    logic [DW-1:0] slice_data [NPORTS];

    logic          disp_full_q, disp_full_d;
    logic [DW-1:0] disp_data_q, disp_data_d;
    logic [PW-1:0] ptr_q, ptr_d;

    logic          disp_free;
    logic          grant_found;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] cand;
    logic [DW-1:0] stamped;
    logic          disp_accept;

    logic          dack_full_q, dack_full_d;
    logic [AW-1:0] dack_data_q, dack_data_d;
    logic [PW-1:0] dack_sel_q, dack_sel_d;
    logic          dack_free;
    logic          dack_load;

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_slice
            assign slice_data[gi]    = l2_disp[gi*DW +: DW];
            assign l2_disp_retry[gi] = l2_disp_valid[gi]
                                     & ~(disp_accept & (grant_idx == PW'(gi)));
        end
    endgenerate

    // Walk from the highest offset down so the last hit is the one closest to ptr.
    always_comb begin
        disp_free   = ~disp_full_q | ~dr_disp_retry;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            cand = ptr_q + PW'(k);
            if (l2_disp_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        disp_accept = disp_free & grant_found;

        stamped = slice_data[grant_idx];
        stamped[NID_LSB+1:NID_LSB] = 2'(grant_idx);

        disp_full_d = disp_full_q;
        disp_data_d = disp_data_q;
        ptr_d       = ptr_q;
        if (disp_accept) begin
            disp_full_d = 1'b1;
            disp_data_d = stamped;
            ptr_d       = grant_idx + PW'(1);
        end else if (disp_full_q & ~dr_disp_retry) begin
            disp_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_full_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            disp_full_q <= disp_full_d;
            ptr_q       <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        disp_data_q <= disp_data_d;
    end

    assign dr_disp_valid = disp_full_q;
    assign dr_disp       = disp_data_q;

    // Only the slice currently addressed by the held dack can stall it.
    always_comb begin
        dack_free   = ~dack_full_q | ~l2_dack_retry[dack_sel_q];
        dack_load   = dr_dack_valid & dack_free;
        dack_full_d = dack_full_q;
        dack_data_d = dack_data_q;
        dack_sel_d  = dack_sel_q;
        if (dack_load) begin
            dack_full_d = 1'b1;
            dack_data_d = dr_dack;
            dack_sel_d  = dr_dack[NID_LSB +: PW];
        end else if (dack_full_q & ~l2_dack_retry[dack_sel_q]) begin
            dack_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dack_full_q <= 1'b0;
            dack_sel_q  <= '0;
        end else begin
            dack_full_q <= dack_full_d;
            dack_sel_q  <= dack_sel_d;
        end
    end

    always_ff @(posedge clk) begin
        dack_data_q <= dack_data_d;
    end

    assign dr_dack_retry = dr_dack_valid & ~dack_free;
    assign l2_dack_valid = dack_full_q ? (NPORTS'(1) << dack_sel_q) : '0;
    assign l2_dack       = dack_data_q;

`ifdef ARBL2DR_PERF_EN
    logic [15:0] cnt_q [NPORTS];
    logic [15:0] cnt_d [NPORTS];

    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_perf
            always_comb begin
                cnt_d[gi] = cnt_q[gi];
                if (disp_accept && (grant_idx == PW'(gi)) && (cnt_q[gi] != 16'hFFFF)) begin
                    cnt_d[gi] = cnt_q[gi] + 16'd1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q[gi] <= 16'd0;
                end else begin
                    cnt_q[gi] <= cnt_d[gi];
                end
            end

            assign perf_grant_cnt[gi*16 +: 16] = cnt_q[gi];
        end
    endgenerate
`endif

endmodule
